// File: rtl/alu_pkg.sv
// Shared types and helpers for the arbitrated ALU: opcode and FSM encodings,
// datapath width and the parity helper used by the ALU.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OPC_ADD    = 2'b00,
        OPC_SHIFT  = 2'b01,
        OPC_PARITY = 2'b10,
        OPC_UNDEF  = 2'b11
    } opc_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_e;

    function automatic logic parity32(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational 32-bit ALU: add, logical left shift (saturating to 0
// for shift amounts of 32 or more), parity, and undefined opcode yielding 0.
module alu
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [1:0]        OPC,
    output logic [DATA_W-1:0] R
);

    // Opcode decode and result selection
    always_comb begin
        R = '0;
        case (opc_e'(OPC))
            OPC_ADD: begin
                R = A + B;
            end
            OPC_SHIFT: begin
                if (B >= 32'd32) begin
                    R = '0;
                end else begin
                    R = A << B[4:0];
                end
            end
            OPC_PARITY: begin
                R = {{(DATA_W-1){1'b0}}, parity32(A)};
            end
            OPC_UNDEF: begin
                R = '0;
            end
            default: begin
                R = '0;
            end
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between N_REQ valid/ready requesters.
// Each operation runs IDLE (grant) -> EXEC (compute) -> RESP (hold until taken).
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int GW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*2-1:0]      req_opc,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_r,
    output logic                    busy,
    output logic [GW-1:0]           grant_id
);

    state_e              r_state;
    logic [GW-1:0]       r_rr;
    logic [GW-1:0]       r_grant;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [1:0]          r_opc;
    logic [DATA_W-1:0]   r_rsp_r;

    state_e              w_next_state;
    logic [N_REQ-1:0]    w_req_ready;
    logic [N_REQ-1:0]    w_rsp_valid;
    logic                w_accept;
    logic                w_release;
    logic [GW:0]         w_pick_res;
    logic                w_found;
    logic [GW-1:0]       w_pick;
    logic [GW-1:0]       w_rr_next;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic [1:0]          w_sel_opc;
    logic [DATA_W-1:0]   w_alu_r;

    // Returns {found, index} of the first valid request searching rr, rr+1, ... mod N_REQ.
    function automatic logic [GW:0] rr_pick(input logic [N_REQ-1:0] v, input logic [GW-1:0] rr);
        logic [GW:0]  res;
        int unsigned  idx;
        res = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (32'(rr) + 32'(k)) % 32'(N_REQ);
            if (!res[GW] && v[idx[GW-1:0]]) begin
                res = {1'b1, idx[GW-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign w_pick_res = rr_pick(req_valid, r_rr);
    assign w_found    = w_pick_res[GW];
    assign w_pick     = w_pick_res[GW-1:0];
    assign w_rr_next  = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

    // Operand mux for the winning requester
    always_comb begin
        w_sel_a   = req_a[DATA_W*int'(w_pick) +: DATA_W];
        w_sel_b   = req_b[DATA_W*int'(w_pick) +: DATA_W];
        w_sel_opc = req_opc[2*int'(w_pick) +: 2];
    end

    alu u_alu (
        .A   (r_a),
        .B   (r_b),
        .OPC (r_opc),
        .R   (w_alu_r)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, handshake strobes and per-requester ready/valid decode
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_rsp_valid  = '0;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            IDLE: begin
                // Reset is gated in so ready drops with the asynchronous reset.
                if (w_found && !reset) begin
                    w_req_ready[w_pick] = 1'b1;
                    w_accept            = 1'b1;
                    w_next_state        = EXEC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                w_rsp_valid[r_grant] = 1'b1;
                if (rsp_ready[r_grant]) begin
                    w_release    = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Operand capture, result register and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_opc   <= 2'b00;
            r_grant <= '0;
            r_rr    <= '0;
            r_rsp_r <= '0;
        end else begin
            if (w_accept) begin
                r_a     <= w_sel_a;
                r_b     <= w_sel_b;
                r_opc   <= w_sel_opc;
                r_grant <= w_pick;
            end
            if (r_state == EXEC) begin
                r_rsp_r <= w_alu_r;
            end
            if (w_release) begin
                r_rr <= w_rr_next;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = w_rsp_valid;
    assign rsp_r     = r_rsp_r;
    assign busy      = (r_state != IDLE);
    assign grant_id  = r_grant;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter against an arithmetic
// reference model of the ALU and round-robin grant order.
module tb_alu_arbiter;

    localparam int N  = 2;
    localparam int GW = (N > 1) ? $clog2(N) : 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a = '0;
    logic [N*32-1:0] req_b = '0;
    logic [N*2-1:0]  req_opc = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [31:0]     rsp_r;
    logic            busy;
    logic [GW-1:0]   grant_id;

    int n_assert = 0;
    int n_fail   = 0;
    int m_rr     = 0;
    logic [31:0] opa [N];
    logic [31:0] opb [N];
    logic [1:0]  opo [N];

    alu_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_opc   (req_opc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_r     (rsp_r),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        logic [63:0] t;
        case (op)
            2'd0:    t = 64'(a) + 64'(b);
            2'd1:    t = (b >= 32'd32) ? 64'd0 : 64'(a) * (64'd1 << b);
            2'd2:    t = 64'($countones(a) % 2);
            default: t = 64'd0;
        endcase
        return t[31:0];
    endfunction

    function automatic int model_pick(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [31:0] oh(input int p);
        return 32'd1 << p;
    endfunction

    task automatic drive_reqs(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32]  = opa[i];
            req_b[32*i +: 32]  = opb[i];
            req_opc[2*i +: 2]  = opo[i];
        end
        req_valid = mask;
    endtask

    task automatic scramble();
        for (int i = 0; i < N; i++) begin
            req_a[32*i +: 32] = $urandom;
            req_b[32*i +: 32] = $urandom;
            req_opc[2*i +: 2] = 2'($urandom);
        end
        req_valid = N'($urandom);
    endtask

    // One full operation starting at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic do_op(input string tag, input logic [N-1:0] mask, input int hold);
        int          p;
        logic [31:0] exp_r;
        logic [N-1:0] others;
        p     = model_pick(mask);
        exp_r = ref_alu(opa[p], opb[p], opo[p]);
        drive_reqs(mask);
        rsp_ready = '0;
        #1;
        chk({tag, ".req_ready"}, 32'(req_ready), oh(p));
        chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk({tag, ".exec_busy"}, 32'(busy), 32'd1);
        chk({tag, ".exec_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".exec_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(p));
        scramble();
        @(negedge clk);
        for (int k = 0; k <= hold; k++) begin
            chk({tag, ".rsp_valid"}, 32'(rsp_valid), oh(p));
            chk({tag, ".rsp_r"}, rsp_r, exp_r);
            chk({tag, ".resp_ready"}, 32'(req_ready), 32'd0);
            chk({tag, ".resp_busy"}, 32'(busy), 32'd1);
            others = N'($urandom) & ~N'(oh(p));
            if (k == hold) begin
                rsp_ready = others | N'(oh(p));
                req_valid = '0;
            end else begin
                rsp_ready = others;
                scramble();
            end
            @(negedge clk);
        end
        chk({tag, ".done_busy"}, 32'(busy), 32'd0);
        chk({tag, ".done_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".done_grant"}, 32'(grant_id), 32'(p));
        rsp_ready = '0;
        m_rr = (p + 1) % N;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".rsp_r"}, rsp_r, 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".grant_id"}, 32'(grant_id), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        m_rr  = 0;
    endtask

    initial begin
        int prev;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0; opb[i] = '0; opo[i] = '0;
        end
        @(negedge clk);
        check_reset_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        opa[0] = 32'd3; opb[0] = 32'd5; opo[0] = 2'b00;
        do_op("add_single", 2'b01, 0);

        do_reset();
        opa[0] = 32'd399; opb[0] = 32'd21; opo[0] = 2'b00;
        opa[1] = 32'hF;   opb[1] = 32'd2;  opo[1] = 2'b01;
        do_op("both_first", 2'b11, 0);
        do_op("both_second", 2'b11, 0);

        opa[1] = 32'h00FF01FF; opb[1] = 32'd0; opo[1] = 2'b10;
        do_op("backpressure", 2'b10, 5);

        opa[0] = 32'd4815; opb[0] = 32'd162342; opo[0] = 2'b11;
        do_op("undef", 2'b01, 0);

        opa[1] = 32'd1; opb[1] = 32'd31; opo[1] = 2'b01;
        do_op("shl31", 2'b10, 0);
        opa[1] = 32'hFFFFFFFF; opb[1] = 32'd32; opo[1] = 2'b01;
        do_op("shl32", 2'b10, 1);
        opa[0] = 32'hFFFFFFFF; opb[0] = 32'd1; opo[0] = 2'b00;
        do_op("add_wrap", 2'b01, 0);

        prev = -1;
        for (int n = 0; n < 4; n++) begin
            opa[0] = $urandom; opb[0] = $urandom; opo[0] = 2'($urandom);
            opa[1] = $urandom; opb[1] = $urandom_range(0, 40); opo[1] = 2'($urandom);
            do_op("fair", 2'b11, 0);
            chk("fair.no_repeat", 32'(int'(grant_id) != prev), 32'd1);
            prev = int'(grant_id);
        end

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < N; i++) begin
                opa[i] = $urandom;
                opb[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
                opo[i] = 2'($urandom);
            end
            do_op("rand", N'($urandom_range(1, (1 << N) - 1)), $urandom_range(0, 2));
        end

        // Leave rr at 1, then drop an operation in RESP with reset.
        do_reset();
        opa[0] = 32'd7; opb[0] = 32'd9; opo[0] = 2'b00;
        do_op("pre_abort", 2'b01, 0);
        drive_reqs(2'b01);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        chk("abort.rsp_valid_before", 32'(rsp_valid), 32'd1);
        chk("abort.rsp_r_before", rsp_r, 32'd16);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        m_rr  = 0;
        opa[0] = 32'd100; opb[0] = 32'd1; opo[0] = 2'b00;
        opa[1] = 32'd6;   opb[1] = 32'd0; opo[1] = 2'b10;
        do_op("post_abort_rr0", 2'b11, 0);
        opa[1] = 32'd11; opb[1] = 32'd22; opo[1] = 2'b00;
        do_op("post_abort_req1", 2'b10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
